square_sweep_unit: RTL and testbench

Parametrised sweep unit for the APU square channels: period register, shifter, adder with selectable carry-in mode, mute detection and sweep divider in one clocked block. It generalises the fixed 11-bit square adder to any width. Square1 and Square2 become two instances that differ only in CARRY_MODE. It sits between the register-write decoder and the square channel timer, and is clocked by the half-frame strobe from the frame counter.

---
 rtl/square_sweep_unit_pkg.sv | 12 +
 rtl/square_sweep_unit_if.sv | 33 +++
 rtl/square_sweep_unit_adder.sv | 24 ++
 rtl/square_sweep_unit.sv | 107 ++++++++++
 tb/tb_square_sweep_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/square_sweep_unit_pkg.sv
// Shared constants for the APU square-channel sweep unit: carry modes,
// default field widths and the mute threshold.
package apu_sweep_pkg;

  localparam int SQ1_CARRY_MODE  = 1;
  localparam int SQ2_CARRY_MODE  = 0;
  localparam int WIDTH_DEF       = 11;
  localparam int SH_W_DEF        = 3;
  localparam int DIV_W_DEF       = 3;
  localparam int MIN_PERIOD_DEF  = 8;

endpackage

// File: rtl/square_sweep_unit_if.sv
// Register-write and channel-timer signals of one sweep unit, seen from the
// decoder (master) and from the sweep unit itself (slave).
interface square_sweep_unit_if
  import apu_sweep_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SH_W  = SH_W_DEF,
  parameter int DIV_W = DIV_W_DEF
);
  logic             half_frame;
  logic             sweep_wr;
  logic             sweep_en;
  logic [DIV_W-1:0] sweep_div;
  logic             sweep_neg;
  logic [SH_W-1:0]  sweep_sh;
  logic             freq_wr;
  logic [WIDTH-1:0] freq_data;
  logic [WIDTH-1:0] freq;
  logic             mute;
  logic             sweep_upd;

  modport master (
    output half_frame, sweep_wr, sweep_en, sweep_div, sweep_neg, sweep_sh,
           freq_wr, freq_data,
    input  freq, mute, sweep_upd
  );

  modport slave (
    input  half_frame, sweep_wr, sweep_en, sweep_div, sweep_neg, sweep_sh,
           freq_wr, freq_data,
    output freq, mute, sweep_upd
  );
endinterface

// File: rtl/square_sweep_unit_adder.sv
// Parametrised ripple-carry adder with explicit carry-in and carry-out,
// kept stand-alone so it can be swept exhaustively on its own.
module square_sweep_adder #(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  always_comb begin
    logic c;
    c     = cin_i;
    sum_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/square_sweep_unit.sv
// Sweep unit for one APU square channel: period register, shift/add target,
// mute detection and half-frame sweep divider.
module square_sweep_unit
  import apu_sweep_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int SH_W       = SH_W_DEF,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int CARRY_MODE = SQ1_CARRY_MODE,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic                ACLK,
  input  logic                n_RES,
  square_sweep_unit_if.slave  bus
);

  logic [WIDTH-1:0] freq_q, freq_d;
  logic             en_q, en_d;
  logic [DIV_W-1:0] p_q, p_d;
  logic             neg_q, neg_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             reload_q, reload_d;
  logic             upd_q, upd_d;

  logic [WIDTH-1:0] delta;
  logic [WIDTH-1:0] addend;
  logic             cin;
  logic [WIDTH-1:0] target;
  logic             cout;
  logic             mute;

  assign delta  = freq_q >> sh_q;
  assign addend = neg_q ? ~delta : delta;
  // Square1 negates in ones' complement (one lower than Square2).
  assign cin    = neg_q & (CARRY_MODE == 0);

  square_sweep_adder #(.WIDTH(WIDTH)) u_adder (
    .a_i   (freq_q),
    .b_i   (addend),
    .cin_i (cin),
    .sum_o (target),
    .cout_o(cout)
  );

  assign mute = (freq_q < WIDTH'(MIN_PERIOD)) | (~neg_q & cout);

  always_comb begin
    freq_d   = freq_q;
    en_d     = en_q;
    p_d      = p_q;
    neg_d    = neg_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    upd_d    = 1'b0;

    if (bus.half_frame) begin
      upd_d = (cnt_q == '0) & en_q & (sh_q != '0) & ~mute;
      if (upd_d) freq_d = target;
      if ((cnt_q == '0) | reload_q) begin
        cnt_d    = p_q;
        reload_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    // A direct period write overrides the sweep result; the new fields and
    // reload flag only become visible after this edge.
    if (bus.freq_wr) freq_d = bus.freq_data;
    if (bus.sweep_wr) begin
      en_d     = bus.sweep_en;
      p_d      = bus.sweep_div;
      neg_d    = bus.sweep_neg;
      sh_d     = bus.sweep_sh;
      reload_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge n_RES) begin
    if (!n_RES) begin
      freq_q   <= '0;
      en_q     <= 1'b0;
      p_q      <= '0;
      neg_q    <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
      reload_q <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      freq_q   <= freq_d;
      en_q     <= en_d;
      p_q      <= p_d;
      neg_q    <= neg_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      upd_q    <= upd_d;
    end
  end

  assign bus.freq      = freq_q;
  assign bus.mute      = mute;
  assign bus.sweep_upd = upd_q;

endmodule

// File: tb/tb_square_sweep_unit.sv
// Drives a Square1 and a Square2 sweep unit with identical stimulus and
// compares both against an arithmetic reference model.
module tb_square_sweep_unit;
  import apu_sweep_pkg::*;

  logic        ACLK = 1'b0;
  logic        n_RES = 1'b0;
  logic        hf = 0, swr = 0, fwr = 0, en = 0, neg = 0;
  logic [2:0]  p = 0, sh = 0;
  logic [10:0] fdata = 0;

  int n_checks = 0;
  int n_errors = 0;

  square_sweep_unit_if if1 ();
  square_sweep_unit_if if2 ();

  assign if1.half_frame = hf;    assign if2.half_frame = hf;
  assign if1.sweep_wr   = swr;   assign if2.sweep_wr   = swr;
  assign if1.sweep_en   = en;    assign if2.sweep_en   = en;
  assign if1.sweep_div  = p;     assign if2.sweep_div  = p;
  assign if1.sweep_neg  = neg;   assign if2.sweep_neg  = neg;
  assign if1.sweep_sh   = sh;    assign if2.sweep_sh   = sh;
  assign if1.freq_wr    = fwr;   assign if2.freq_wr    = fwr;
  assign if1.freq_data  = fdata; assign if2.freq_data  = fdata;

  square_sweep_unit #(.CARRY_MODE(SQ1_CARRY_MODE)) sq1 (.ACLK(ACLK), .n_RES(n_RES), .bus(if1));
  square_sweep_unit #(.CARRY_MODE(SQ2_CARRY_MODE)) sq2 (.ACLK(ACLK), .n_RES(n_RES), .bus(if2));

  always #5 ACLK = ~ACLK;

  logic [10:0] dut_freq [2];
  logic        dut_mute [2];
  logic        dut_upd  [2];
  assign dut_freq[0] = if1.freq;      assign dut_freq[1] = if2.freq;
  assign dut_mute[0] = if1.mute;      assign dut_mute[1] = if2.mute;
  assign dut_upd[0]  = if1.sweep_upd; assign dut_upd[1]  = if2.sweep_upd;

  // Reference state: period and update pulse per channel, shared sweep fields.
  int m_freq [2];
  int m_upd  [2];
  int m_en, m_p, m_n, m_sh, m_div, m_reload;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_mute(int f, int n, int s);
    return ((f < 8) || (n == 0 && f + (f >> s) > 2047)) ? 1 : 0;
  endfunction

  // Square1 (k=0) subtracts one extra on negate.
  function automatic int ref_target(int f, int n, int s, int k);
    int d = f >> s;
    if (n == 0) return (f + d) & 'h7FF;
    return (f - d - ((k == 0) ? 1 : 0)) & 'h7FF;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin m_freq[k] = 0; m_upd[k] = 0; end
    m_en = 0; m_p = 0; m_n = 0; m_sh = 0; m_div = 0; m_reload = 0;
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("sq%0d_freq", k + 1), 32'(dut_freq[k]), 32'(m_freq[k]));
      chk($sformatf("sq%0d_upd", k + 1),  32'(dut_upd[k]),  32'(m_upd[k]));
      chk($sformatf("sq%0d_mute", k + 1), 32'(dut_mute[k]),
          32'(ref_mute(m_freq[k], m_n, m_sh)));
    end
  endtask

  task automatic step();
    int nf [2];
    int nu [2];
    for (int k = 0; k < 2; k++) begin
      nu[k] = (hf && m_div == 0 && m_en != 0 && m_sh != 0 &&
               ref_mute(m_freq[k], m_n, m_sh) == 0) ? 1 : 0;
      nf[k] = (nu[k] != 0) ? ref_target(m_freq[k], m_n, m_sh, k) : m_freq[k];
      if (fwr) nf[k] = int'(fdata);
    end
    if (hf) begin
      if (m_div == 0 || m_reload != 0) begin m_div = m_p; m_reload = 0; end
      else m_div = m_div - 1;
    end
    if (swr) begin
      m_en = int'(en); m_p = int'(p); m_n = int'(neg); m_sh = int'(sh); m_reload = 1;
    end
    for (int k = 0; k < 2; k++) begin m_freq[k] = nf[k]; m_upd[k] = nu[k]; end
    @(posedge ACLK); #1;
    hf = 0; swr = 0; fwr = 0;
    compare();
  endtask

  task automatic wr_freq(input int v);
    fwr = 1; fdata = 11'(v); step();
  endtask

  task automatic wr_sweep(input int e, input int pp, input int n, input int s);
    swr = 1; en = 1'(e); p = 3'(pp); neg = 1'(n); sh = 3'(s); step();
  endtask

  task automatic pulse_hf();
    hf = 1; step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int mask;
    model_reset();
    repeat (2) @(posedge ACLK);
    #1;
    compare();
    n_RES = 1;
    step();

    // Basic upward sweep.
    wr_freq('h100);
    wr_sweep(1, 0, 0, 1);
    pulse_hf();
    chk("t1_freq", 32'(if1.freq), 32'h180);
    chk("t1_upd", 32'(if1.sweep_upd), 32'd1);
    step();
    chk("t1_upd_clear", 32'(if1.sweep_upd), 32'd0);

    // Negate: ones' versus two's complement.
    wr_freq('h100);
    wr_sweep(1, 0, 1, 1);
    pulse_hf();
    chk("t2_sq1", 32'(if1.freq), 32'h07F);
    chk("t2_sq2", 32'(if2.freq), 32'h080);

    // Overflow and low-period mute.
    wr_freq('h600);
    wr_sweep(1, 0, 0, 1);
    chk("t3_ovf_mute", 32'(if1.mute), 32'd1);
    pulse_hf();
    chk("t3_ovf_hold", 32'(if1.freq), 32'h600);
    wr_freq('h007);
    chk("t3_mute7", 32'(if2.mute), 32'd1);
    wr_freq('h008);
    chk("t3_mute8", 32'(if2.mute), 32'd0);

    // Divider with P=3, then reload forced mid-count.
    wr_freq('h100);
    wr_sweep(1, 3, 1, 4);
    mask = 0;
    for (int i = 0; i < 12; i++) begin
      pulse_hf();
      if (if1.sweep_upd) mask |= (1 << i);
      step();
    end
    chk("t4_div_pattern", 32'(mask), 32'h111);
    mask = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) wr_sweep(1, 3, 1, 4);
      pulse_hf();
      if (if1.sweep_upd) mask |= (1 << i);
    end
    chk("t4_reload_pattern", 32'(mask), 32'h41);

    // Collisions: freq_wr with update, sweep_wr with half_frame.
    repeat (3) pulse_hf();
    hf = 1; fwr = 1; fdata = 11'h234; step();
    chk("t5_fwr_wins", 32'(if2.freq), 32'h234);
    chk("t5_upd_pulse", 32'(if2.sweep_upd), 32'd1);
    repeat (3) pulse_hf();
    hf = 1; swr = 1; en = 1; p = 5; neg = 1; sh = 4; step();
    repeat (8) pulse_hf();

    // Asynchronous reset mid-count.
    wr_sweep(1, 7, 0, 2);
    repeat (4) pulse_hf();
    #2;
    n_RES = 0;
    #1;
    model_reset();
    chk("t6_rst_freq", 32'(if1.freq), 32'd0);
    chk("t6_rst_mute", 32'(if1.mute), 32'd1);
    chk("t6_rst_upd", 32'(if2.sweep_upd), 32'd0);
    repeat (2) @(posedge ACLK);
    #1;
    n_RES = 1;
    pulse_hf();
    chk("t6_no_upd", 32'(if1.sweep_upd), 32'd0);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      hf = ($urandom_range(0, 2) == 0);
      swr = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 3) != 0);
      p = 3'($urandom_range(0, 7));
      neg = 1'($urandom_range(0, 1));
      sh = 3'($urandom_range(0, 7));
      fwr = ($urandom_range(0, 9) == 0);
      fdata = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 16))
                                          : 11'($urandom_range(0, 2047));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
